timer_peripheral: RTL

TIMER_PERIPHERAL -- requirements
Module: timer_peripheral

---
 rtl/timer_peripheral.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/timer_peripheral.sv
// timer_peripheral: memory-mapped 16-bit tick timer with prescaler,
// compare/expire, one-shot or auto-reload operation and interrupt.
module timer_peripheral #(
    parameter logic [8:0]  BASE_ADDR = 9'h180,
    parameter int unsigned PRESCALE  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        irq
);
    localparam logic [6:0]  M_READ  = 7'b1100000;
    localparam logic [6:0]  M_WRITE = 7'b1110000;
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic        r_auto;
    logic        r_ien;
    logic        r_expired;
    logic [15:0] r_period;
    logic [15:0] r_count;
    logic [15:0] r_pre;

    logic [9:0]  w_rel;
    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_per;
    logic        w_wr_cnt;
    logic        w_wr_stat;
    logic        w_load;
    logic        w_stop;
    logic        w_tick;
    logic        w_step;
    logic        w_hit;
    logic [15:0] w_rdata;

    // Addresses below the base wrap to large values, so one compare suffices.
    assign w_rel     = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
    assign w_sel     = (w_rel < 10'd4);
    assign w_off     = w_rel[1:0];
    assign w_wr      = (mem_cmd == M_WRITE) && w_sel;
    assign w_rd      = (mem_cmd == M_READ) && w_sel;
    assign w_wr_ctrl = w_wr && (w_off == 2'd0);
    assign w_wr_per  = w_wr && (w_off == 2'd1);
    assign w_wr_cnt  = w_wr && (w_off == 2'd2);
    assign w_wr_stat = w_wr && (w_off == 2'd3);

    // A COUNT load or clear_count beats a tick; so does a CTRL stop.
    assign w_load = w_wr_cnt || (w_wr_ctrl && write_data[2]);
    assign w_stop = w_wr_ctrl && !write_data[0];
    assign w_tick = (r_state == S_RUN) && (r_pre == PRE_MAX);
    assign w_step = w_tick && !w_load && !w_stop;
    assign w_hit  = w_step && (r_count == r_period);

    // Next-state logic: a CTRL write always decides the new run state.
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_wr_ctrl && write_data[0]) w_state_n = S_RUN;
            end
            S_RUN: begin
                if (w_wr_ctrl) w_state_n = write_data[0] ? S_RUN : S_IDLE;
                else if (w_hit && !r_auto) w_state_n = S_DONE;
            end
            S_DONE: begin
                if (w_wr_ctrl) w_state_n = write_data[0] ? S_RUN : S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State register and the plain CTRL/PERIOD fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_auto   <= 1'b0;
            r_ien    <= 1'b0;
            r_period <= 16'd0;
        end else begin
            r_state <= w_state_n;
            if (w_wr_ctrl) begin
                r_auto <= write_data[1];
                r_ien  <= write_data[3];
            end
            if (w_wr_per) r_period <= write_data;
        end
    end

    // Prescaler runs only while staying in RUN; anything else parks it at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= 16'd0;
        end else if ((r_state == S_RUN) && (w_state_n == S_RUN)
                     && !w_load && !w_tick) begin
            r_pre <= r_pre + 16'd1;
        end else begin
            r_pre <= 16'd0;
        end
    end

    // COUNT: bus load, clear, reset on match, else increment on tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (w_wr_cnt) begin
            r_count <= write_data;
        end else if (w_load || w_hit) begin
            r_count <= 16'd0;
        end else if (w_step) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Expired flag: a new expiry wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expired <= 1'b0;
        end else if (w_hit) begin
            r_expired <= 1'b1;
        end else if (w_wr_stat && write_data[0]) begin
            r_expired <= 1'b0;
        end
    end

    // Register read mux; enable reflects the RUN state.
    always_comb begin
        w_rdata = 16'd0;
        unique case (w_off)
            2'd0: w_rdata = {12'd0, r_ien, 1'b0, r_auto, r_state == S_RUN};
            2'd1: w_rdata = r_period;
            2'd2: w_rdata = r_count;
            2'd3: w_rdata = {15'd0, r_expired};
            default: w_rdata = 16'd0;
        endcase
    end

    assign read_data = w_rd ? w_rdata : 16'bz;
    assign irq       = r_expired & r_ien;
endmodule
